fixed_to_double: RTL

- Iterative converter from a parametrised fixed-point sample to an IEEE-754 binary64 word.
- Supports sign-magnitude or two's-complement input, a fixed binary-point position, round-to-nearest-even for inputs wider than 53 magnitude bits, and a correctly encoded ±0.0.
- Uses valid/ready handshakes on both sides.
- Sits between the ADC/sample front end and the double-precision echo-cancellation datapath, replacing the fixed 16-bit sign-magnitude converter.

---
 rtl/fp64_pkg.sv | 16 +
 rtl/fp_round_rne.sv | 55 +++++
 rtl/fixed_to_double.sv | 122 ++++++++++++
 3 files changed

// File: rtl/fp64_pkg.sv
// Shared binary64 field widths, bias and the converter state encoding.
// The downstream double-precision adder and multiplier import this package as well.
package fp64_pkg;

    localparam int EXP_W    = 11;
    localparam int MAN_W    = 52;
    localparam int EXP_BIAS = 1023;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        NORM  = 2'd1,
        ROUND = 2'd2,
        OUT   = 2'd3
    } fp_state_t;

endpackage

// File: rtl/fp_round_rne.sv
// Combinational pack of a normalised magnitude into binary64 exponent/mantissa
// fields, with round-to-nearest-even when more than 52 fraction bits are present.
module fp_round_rne
    import fp64_pkg::*;
#(
    parameter int MAG_W     = 16,
    parameter int FRAC_BITS = 0
) (
    input  logic [MAG_W-1:0] mag,
    input  logic [6:0]       cnt,
    output logic [EXP_W-1:0] biased_exp,
    output logic [MAN_W-1:0] mantissa
);

    localparam int FW      = MAG_W - 1;
    localparam int EXP_OFF = EXP_BIAS - FRAC_BITS;

    logic [FW-1:0]    frac;
    logic [MAN_W-1:0] man_pre;
    logic             carry;

    assign frac = mag[MAG_W-2:0];

    generate
        if (FW <= MAN_W) begin : g_pad
            assign man_pre = MAN_W'(frac) << (MAN_W - FW);
            assign carry   = 1'b0;
        end else begin : g_rne
            localparam int D = FW - MAN_W;
            logic [MAN_W-1:0] trunc;
            logic [MAN_W:0]   sum;
            logic             guard;
            logic             sticky;
            logic             inc;

            assign trunc = frac[FW-1:D];
            assign guard = frac[D-1];
            if (D >= 2) begin : g_sticky
                assign sticky = |frac[D-2:0];
            end else begin : g_no_sticky
                assign sticky = 1'b0;
            end
            assign inc     = guard & (sticky | trunc[0]);
            assign sum     = {1'b0, trunc} + {{MAN_W{1'b0}}, inc};
            // An all-ones mantissa rolls over to zero; the carry moves into the exponent.
            assign carry   = sum[MAN_W];
            assign man_pre = sum[MAN_W-1:0];
        end
    endgenerate

    // A magnitude without its leading one is zero and gets a zero exponent field.
    assign biased_exp = mag[MAG_W-1] ? (EXP_W'(cnt) + EXP_W'(EXP_OFF) + EXP_W'(carry)) : '0;
    assign mantissa   = man_pre;

endmodule

// File: rtl/fixed_to_double.sv
// Iterative fixed-point to IEEE-754 binary64 converter with valid/ready on both
// sides: one normalising shift per cycle, then a rounding/pack cycle.
module fixed_to_double
    import fp64_pkg::*;
#(
    parameter int IN_W        = 16,
    parameter int SIGNED_MODE = 0,
    parameter int FRAC_BITS   = 0
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [IN_W-1:0] in_data,
    input  logic            in_valid,
    output logic            in_ready,
    output logic [63:0]     out_data,
    output logic            out_valid,
    input  logic            out_ready
);

    localparam int MAG_W = IN_W;

    generate
        if (IN_W < 2 || IN_W > 64) begin : g_bad_in_w
            $error("fixed_to_double: IN_W must be within 2..64");
        end
        if (FRAC_BITS < 0 || FRAC_BITS > 1000) begin : g_bad_frac
            $error("fixed_to_double: FRAC_BITS must be within 0..1000");
        end
    endgenerate

    fp_state_t        state_reg, state_next;
    logic [MAG_W-1:0] mag_reg, mag_next;
    logic [6:0]       cnt_reg, cnt_next;
    logic             s_reg, s_next;
    logic [63:0]      out_data_reg, out_data_next;

    logic [MAG_W-1:0] mag_in;
    logic             s_in;
    logic [EXP_W-1:0] rnd_exp;
    logic [MAN_W-1:0] rnd_man;

    generate
        if (SIGNED_MODE != 0) begin : g_twos
            // Negation of the most negative code wraps to 2^(IN_W-1), which is the correct magnitude.
            assign s_in   = in_data[IN_W-1];
            assign mag_in = s_in ? (~in_data + 1'b1) : in_data;
        end else begin : g_signmag
            assign s_in   = in_data[IN_W-1];
            assign mag_in = {1'b0, in_data[IN_W-2:0]};
        end
    endgenerate

    fp_round_rne #(
        .MAG_W     (MAG_W),
        .FRAC_BITS (FRAC_BITS)
    ) u_round (
        .mag        (mag_reg),
        .cnt        (cnt_reg),
        .biased_exp (rnd_exp),
        .mantissa   (rnd_man)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg    <= IDLE;
            mag_reg      <= '0;
            cnt_reg      <= '0;
            s_reg        <= 1'b0;
            out_data_reg <= '0;
        end else begin
            state_reg    <= state_next;
            mag_reg      <= mag_next;
            cnt_reg      <= cnt_next;
            s_reg        <= s_next;
            out_data_reg <= out_data_next;
        end
    end

    always_comb begin
        state_next    = state_reg;
        mag_next      = mag_reg;
        cnt_next      = cnt_reg;
        s_next        = s_reg;
        out_data_next = out_data_reg;
        case (state_reg)
            IDLE: begin
                if (in_valid) begin
                    s_next     = s_in;
                    mag_next   = mag_in;
                    cnt_next   = 7'(MAG_W - 1);
                    state_next = NORM;
                end
            end
            NORM: begin
                if (mag_reg == '0) begin
                    out_data_next = {s_reg, 63'b0};
                    state_next    = OUT;
                end else if (mag_reg[MAG_W-1]) begin
                    state_next = ROUND;
                end else begin
                    mag_next = mag_reg << 1;
                    cnt_next = cnt_reg - 7'd1;
                end
            end
            ROUND: begin
                out_data_next = {s_reg, rnd_exp, rnd_man};
                state_next    = OUT;
            end
            OUT: begin
                if (out_ready) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    assign in_ready  = (state_reg == IDLE);
    assign out_valid = (state_reg == OUT);
    assign out_data  = out_data_reg;

endmodule
